// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction memory loader.
package mips_pkg;

  // Bytes per MIPS instruction word.
  localparam int unsigned WORD_BYTES = 4;

  // Width of the byte-lane index within a word.
  localparam int unsigned LANE_W = $clog2(WORD_BYTES);

  // Index of the last byte lane of a word.
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(WORD_BYTES - 1);

  // Big-endian lane to bit offset: lane 0 -> [31:24], lane 3 -> [7:0].
  // Packed element [0] is the rightmost field of the concatenation.
  localparam logic [WORD_BYTES-1:0][4:0] LANE_OFFSET = {5'd0, 5'd8, 5'd16, 5'd24};

  // Loader FSM states. CHECK is only reachable when the checksum feature is built in.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FLUSH = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } loader_state_t;

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the loader.
// slave: the loader's view. master: the byte source / memory side.
interface instr_mem_loader_if #(
  parameter int unsigned ADDR_WIDTH = 32
) ();

  // Byte stream
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_last;
  logic                  in_ready;

  // Instruction memory write port
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

endinterface

// File: rtl/loader_word_packer.sv
// Packs accepted bytes into big-endian 32-bit words. A word is emitted (one-cycle
// o_word_valid the cycle after its final byte) when lane 3 fills or when the byte
// is flagged last; unfilled low lanes are zero because the accumulator restarts at 0.
module loader_word_packer
  import mips_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_byte,
  input  logic        i_accept,
  input  logic        i_last,
  input  logic        i_clear,
  output logic [31:0] o_word,
  output logic        o_word_valid
);

  logic [LANE_W-1:0] r_lane;
  logic [31:0]       r_acc;
  logic [31:0]       r_word;
  logic              r_valid;

  logic [31:0]       w_merged;
  logic              w_complete;

  // Merge the incoming byte into its lane and decide whether the word closes.
  always_comb begin
    w_merged   = r_acc | ({24'd0, i_byte} << LANE_OFFSET[r_lane]);
    w_complete = i_accept && ((r_lane == LANE_LAST) || i_last);
  end

  // Accumulator, lane pointer and registered output word.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lane  <= '0;
      r_acc   <= '0;
      r_word  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_complete && !i_clear;
      if (i_clear) begin
        r_lane <= '0;
        r_acc  <= '0;
      end else if (i_accept) begin
        if (w_complete) begin
          r_word <= w_merged;
          r_acc  <= '0;
          r_lane <= '0;
        end else begin
          r_acc  <= w_merged;
          r_lane <= r_lane + LANE_W'(1);
        end
      end
    end
  end

  assign o_word       = r_word;
  assign o_word_valid = r_valid;

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction memory loader: fills the instruction memory from a byte stream and
// holds the core in reset (o_cpu_rst) until the program load completes.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing two's-complement
// checksum byte (state CHECK) and the o_csum_err output.
module instr_mem_loader
  import mips_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned           MEM_DEPTH  = 256,
  localparam int unsigned          CNT_W      = $clog2(MEM_DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  instr_mem_loader_if.slave io_bus,
  output logic              o_cpu_rst,
  output logic              o_done,
  output logic              o_overflow,
`ifdef LOADER_CHECKSUM_EN
  output logic              o_csum_err,
`endif
  output logic [CNT_W-1:0]  o_word_count
);

  loader_state_t         r_state;
  loader_state_t         w_state_d;

  logic [ADDR_WIDTH-1:0] r_ptr;        // address of the next word to write
  logic [ADDR_WIDTH-1:0] r_last_addr;  // address shown on mem_addr when idle
  logic [CNT_W-1:0]      r_word_count;
  logic                  r_overflow;

  logic                  w_in_ready;
  logic                  w_cpu_rst;
  logic                  w_done;
  logic                  w_accept;
  logic                  w_clear;
  logic                  w_full;
  logic                  w_pack_accept;
  logic                  w_word_valid;
  logic                  w_we;
  logic [31:0]           w_word;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            r_csum;
  logic                  r_csum_err;
  logic [7:0]            w_csum_sum;
`endif

  // Ready is a pure function of state so acceptance never loops through the FSM.
`ifdef LOADER_CHECKSUM_EN
  assign w_in_ready = (r_state == LOAD) || (r_state == CHECK);
`else
  assign w_in_ready = (r_state == LOAD);
`endif

  assign w_accept      = io_bus.in_valid && w_in_ready;
  assign w_clear       = i_start && ((r_state == IDLE) || (r_state == DONE));
  assign w_full        = (r_word_count == CNT_W'(MEM_DEPTH));
  // Checksum bytes are consumed by the loader itself, never packed.
  assign w_pack_accept = w_accept && (r_state == LOAD);
  // Words past capacity are packed but dropped.
  assign w_we          = w_word_valid && !w_full;

`ifdef LOADER_CHECKSUM_EN
  assign w_csum_sum = r_csum + io_bus.in_data;
`endif

  loader_word_packer u_packer (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_byte      (io_bus.in_data),
    .i_accept    (w_pack_accept),
    .i_last      (io_bus.in_last),
    .i_clear     (w_clear),
    .o_word      (w_word),
    .o_word_valid(w_word_valid)
  );

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  // FSM next state and state-decoded outputs.
  always_comb begin
    w_state_d = r_state;
    w_cpu_rst = 1'b1;
    w_done    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_start) w_state_d = LOAD;
      end
      LOAD: begin
        if (w_accept && io_bus.in_last) w_state_d = FLUSH;
      end
      FLUSH: begin
        // The final (possibly padded) word is written during this cycle.
`ifdef LOADER_CHECKSUM_EN
        w_state_d = CHECK;
`else
        w_state_d = DONE;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (w_accept) w_state_d = DONE;
      end
`endif
      DONE: begin
        w_done = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        w_cpu_rst = r_csum_err;
`else
        w_cpu_rst = 1'b0;
`endif
        if (i_start) w_state_d = LOAD;
      end
      default: begin
        w_state_d = IDLE;
      end
    endcase
  end

  // Address pointer, word counter and sticky overflow flag.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_clear) begin
      r_ptr        <= BASE_ADDR;
      r_last_addr  <= BASE_ADDR;
      r_word_count <= '0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_we) begin
        r_last_addr  <= r_ptr;
        r_ptr        <= r_ptr + ADDR_WIDTH'(WORD_BYTES);
        r_word_count <= r_word_count + CNT_W'(1);
      end
      if (w_word_valid && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running mod-256 byte sum; the error verdict is taken as the checksum byte lands.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_clear) begin
      r_csum     <= '0;
      r_csum_err <= 1'b0;
    end else if (w_accept) begin
      r_csum <= w_csum_sum;
      if (r_state == CHECK) begin
        r_csum_err <= (w_csum_sum != 8'd0);
      end
    end
  end

  assign o_csum_err = r_csum_err;
`endif

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.mem_we    = w_we;
  assign io_bus.mem_addr  = w_we ? r_ptr : r_last_addr;
  assign io_bus.mem_wdata = w_word;

  assign o_cpu_rst    = w_cpu_rst;
  assign o_done       = w_done;
  assign o_overflow   = r_overflow;
  assign o_word_count = r_word_count;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader (MEM_DEPTH=4 so overflow is reachable).
// Expected memory writes are queued by the stimulus; a negedge monitor pops and
// compares them whenever mem_we is seen.
module tb_instr_mem_loader;
  import mips_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          cpu_rst;
  logic          done;
  logic          overflow;
  logic [CW-1:0] word_count;
`ifdef LOADER_CHECKSUM_EN
  logic          csum_err;
`endif

  int            n_checks = 0;
  int            n_pass   = 0;
  logic [7:0]    sum      = 8'd0;
  wr_t           exp_q[$];

  instr_mem_loader_if #(.ADDR_WIDTH(32)) bus ();

  instr_mem_loader #(
    .ADDR_WIDTH(32),
    .BASE_ADDR (32'h0000_0000),
    .MEM_DEPTH (DEPTH)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .io_bus      (bus),
    .o_cpu_rst   (cpu_rst),
    .o_done      (done),
    .o_overflow  (overflow),
`ifdef LOADER_CHECKSUM_EN
    .o_csum_err  (csum_err),
`endif
    .o_word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle(1);
    start = 1'b0;
    sum = 8'd0;
  endtask

  // Waits (bounded) for ready, then presents one byte for one cycle.
  task automatic send_byte(input logic [7:0] b, input logic last);
    int k;
    k = 0;
    while (!bus.in_ready && k < 16) begin
      cycle(1);
      k++;
    end
    check("in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    bus.in_last  = last;
    sum          = sum + b;
    cycle(1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Called right after the last program byte: FLUSH cycle, then (if built) the checksum.
  task automatic finish_load();
    check("flush_not_done", 32'(done), 32'd0);
    check("flush_cpu_rst", 32'(cpu_rst), 32'd1);
`ifdef LOADER_CHECKSUM_EN
    cycle(1);
    send_byte(8'd0 - sum, 1'b0);
    check("csum_err_ok", 32'(csum_err), 32'd0);
`else
    cycle(1);
`endif
  endtask

  // Write monitor.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", bus.mem_addr, 32'hxxxx_xxxx);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("wr_addr", bus.mem_addr, w.addr);
        check("wr_data", bus.mem_wdata, w.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_last  = 1'b0;
    cycle(2);
    rst = 1'b0;
    cycle(1);

    // Reset state
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);

    // Full words, back to back
    pulse_start();
    expect_wr(32'h0, 32'h1234_5678);
    expect_wr(32'h4, 32'h9ABC_DEF0);
    send_byte(8'h12, 1'b0); send_byte(8'h34, 1'b0);
    send_byte(8'h56, 1'b0); send_byte(8'h78, 1'b0);
    send_byte(8'h9A, 1'b0); send_byte(8'hBC, 1'b0);
    send_byte(8'hDE, 1'b0); send_byte(8'hF0, 1'b1);
    finish_load();
    check("full_done", 32'(done), 32'd1);
    check("full_cpu_rst", 32'(cpu_rst), 32'd0);
    check("full_word_count", 32'(word_count), 32'd2);
    check("full_addr_hold", bus.mem_addr, 32'h4);

    // Partial word with gaps and an ignored mid-load start
    pulse_start();
    check("restart_cpu_rst", 32'(cpu_rst), 32'd1);
    check("restart_word_count", 32'(word_count), 32'd0);
    expect_wr(32'h0, 32'h0102_0304);
    expect_wr(32'h4, 32'hEE00_0000);
    send_byte(8'h01, 1'b0); cycle(2);
    send_byte(8'h02, 1'b0);
    start = 1'b1; cycle(1); start = 1'b0;
    send_byte(8'h03, 1'b0); cycle(1);
    send_byte(8'h04, 1'b0); cycle(3);
    send_byte(8'hEE, 1'b1);
    finish_load();
    check("part_done", 32'(done), 32'd1);
    check("part_overflow", 32'(overflow), 32'd0);
    check("part_word_count", 32'(word_count), 32'd2);

    // in_valid while DONE: not accepted, no write
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    check("done_in_ready", 32'(bus.in_ready), 32'd0);
    cycle(1);
    bus.in_valid = 1'b0;
    cycle(2);
    check("done_hold_count", 32'(word_count), 32'd2);
    check("done_hold", 32'(done), 32'd1);

    // Overflow: 20 bytes into 4 words of memory
    pulse_start();
    expect_wr(32'h0, 32'h0102_0304);
    expect_wr(32'h4, 32'h0506_0708);
    expect_wr(32'h8, 32'h090A_0B0C);
    expect_wr(32'hC, 32'h0D0E_0F10);
    for (int i = 1; i <= 20; i++) send_byte(8'(i), (i == 20));
    finish_load();
    check("ovf_overflow", 32'(overflow), 32'd1);
    check("ovf_done", 32'(done), 32'd1);
    check("ovf_word_count", 32'(word_count), 32'd4);
    check("ovf_addr_hold", bus.mem_addr, 32'hC);

    // Reset in the middle of a load
    pulse_start();
    check("ovf_cleared", 32'(overflow), 32'd0);
    expect_wr(32'h0, 32'h1112_1314);
    for (int i = 0; i < 6; i++) send_byte(8'h11 + 8'(i), 1'b0);
    rst = 1'b1;
    cycle(1);
    rst = 1'b0;
    check("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("midrst_word_count", 32'(word_count), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    check("midrst_addr", bus.mem_addr, 32'h0);
    pulse_start();
    expect_wr(32'h0, 32'hA1A2_A3A4);
    send_byte(8'hA1, 1'b0); send_byte(8'hA2, 1'b0);
    send_byte(8'hA3, 1'b0); send_byte(8'hA4, 1'b1);
    finish_load();
    check("reload_done", 32'(done), 32'd1);
    check("reload_word_count", 32'(word_count), 32'd1);

`ifdef LOADER_CHECKSUM_EN
    // Explicit good and bad checksum bytes
    pulse_start();
    expect_wr(32'h0, 32'h0102_0304);
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0); send_byte(8'h04, 1'b1);
    cycle(1);
    check("chk_state_ready", 32'(bus.in_ready), 32'd1);
    send_byte(8'hF6, 1'b0);
    check("csum_good_err", 32'(csum_err), 32'd0);
    check("csum_good_cpu_rst", 32'(cpu_rst), 32'd0);
    check("csum_good_done", 32'(done), 32'd1);

    pulse_start();
    expect_wr(32'h0, 32'h0102_0304);
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0); send_byte(8'h04, 1'b1);
    cycle(1);
    send_byte(8'hF5, 1'b0);
    check("csum_bad_err", 32'(csum_err), 32'd1);
    check("csum_bad_cpu_rst", 32'(cpu_rst), 32'd1);
    check("csum_bad_done", 32'(done), 32'd1);
`endif

    cycle(3);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
